// File: rtl/rom_scanner.sv
// Address sequencer for a small combinational lookup ROM: walks every address once per
// start, registers each word onto a valid/ready stream and keeps a running sum.
module rom_scanner #(
  parameter int ADDR_W   = 3,
  parameter int DATA_W   = 4,
  parameter int TICK_DIV = 50_000_000,
  parameter int SUM_W    = ADDR_W + DATA_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              mode_auto,
  input  logic              step,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [DATA_W-1:0] rom_data,
  output logic [DATA_W-1:0] out_data,
  output logic [ADDR_W-1:0] out_addr,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [SUM_W-1:0]  sum,
  output logic              busy,
  output logic              done
);

  localparam int TW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [TW-1:0] TICK_MAX = TW'(TICK_DIV - 1);

  typedef enum logic [1:0] {S_IDLE, S_FETCH, S_OFFER, S_WAIT} state_t;

  state_t            r_state;
  state_t            w_next;
  logic [ADDR_W-1:0] r_addr;
  logic [TW-1:0]     r_tick;
  logic              r_mode;
  logic [DATA_W-1:0] r_out_data;
  logic [ADDR_W-1:0] r_out_addr;
  logic              r_out_valid;
  logic [SUM_W-1:0]  r_sum;
  logic              r_busy;
  logic              r_done;
  logic              w_accept;
  logic              w_last;

  assign w_accept = r_out_valid & out_ready;
  assign w_last   = (r_addr == '1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (start) w_next = S_FETCH;
      S_FETCH: w_next = S_OFFER;
      S_OFFER: if (w_accept) w_next = w_last ? S_IDLE : S_WAIT;
      S_WAIT: begin
        if (r_mode) begin
          if (r_tick == TICK_MAX) w_next = S_FETCH;
        end else if (step) begin
          w_next = S_FETCH;
        end
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_addr      <= '0;
      r_tick      <= '0;
      r_mode      <= 1'b0;
      r_out_data  <= '0;
      r_out_addr  <= '0;
      r_out_valid <= 1'b0;
      r_sum       <= '0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_addr <= '0;
            r_sum  <= '0;
            r_done <= 1'b0;
            r_busy <= 1'b1;
            r_mode <= mode_auto;
          end
        end
        S_FETCH: begin
          r_out_data  <= rom_data;
          r_out_addr  <= r_addr;
          r_sum       <= r_sum + SUM_W'(rom_data);
          r_out_valid <= 1'b1;
        end
        S_OFFER: begin
          if (w_accept) begin
            r_out_valid <= 1'b0;
            if (w_last) begin
              r_busy <= 1'b0;
              r_done <= 1'b1;
            end else begin
              r_addr <= r_addr + 1'b1;
              r_tick <= '0;
            end
          end
        end
        S_WAIT: begin
          if (r_mode) r_tick <= r_tick + 1'b1;
        end
        default: ;
      endcase
    end
  end

  // Outside a scan the ROM is parked at address 0.
  always_comb begin
    rom_addr = (r_state == S_IDLE) ? '0 : r_addr;
  end

  assign out_data  = r_out_data;
  assign out_addr  = r_out_addr;
  assign out_valid = r_out_valid;
  assign sum       = r_sum;
  assign busy      = r_busy;
  assign done      = r_done;

endmodule

// File: tb/tb_rom_scanner.sv
// Bench for rom_scanner with ROM 0,0,8,5,7,1,0,2 and a 4-cycle auto-step prescaler.
module tb_rom_scanner;

  localparam int ADDR_W   = 3;
  localparam int DATA_W   = 4;
  localparam int TICK_DIV = 4;
  localparam int SUM_W    = ADDR_W + DATA_W;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              start;
  logic              mode_auto;
  logic              step;
  logic [ADDR_W-1:0] rom_addr;
  logic [DATA_W-1:0] rom_data;
  logic [DATA_W-1:0] out_data;
  logic [ADDR_W-1:0] out_addr;
  logic              out_valid;
  logic              out_ready;
  logic [SUM_W-1:0]  sum;
  logic              busy;
  logic              done;

  logic [DATA_W-1:0] rom_tab [8] = '{4'd0, 4'd0, 4'd8, 4'd5, 4'd7, 4'd1, 4'd0, 4'd2};
  logic [ADDR_W+DATA_W-1:0] exp_q [$];

  int n_pass  = 0;
  int n_total = 0;

  rom_scanner #(
    .ADDR_W   (ADDR_W),
    .DATA_W   (DATA_W),
    .TICK_DIV (TICK_DIV),
    .SUM_W    (SUM_W)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .mode_auto (mode_auto),
    .step      (step),
    .rom_addr  (rom_addr),
    .rom_data  (rom_data),
    .out_data  (out_data),
    .out_addr  (out_addr),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .busy      (busy),
    .done      (done)
  );

  always #5 clk = ~clk;

  always_comb rom_data = rom_tab[rom_addr];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", nm, act, exp);
  endtask

  // Monitor: every handshake pops one expected {addr,data} word.
  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_word", {out_addr, out_data}, 32'hFFFF_FFFF);
      end else begin
        chk("word", {out_addr, out_data}, exp_q.pop_front());
      end
    end
  end

  task automatic push_scan();
    logic [ADDR_W-1:0] a;
    for (int unsigned i = 0; i < 8; i++) begin
      a = ADDR_W'(i);
      exp_q.push_back({a, rom_tab[i]});
    end
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic pulse_step();
    step = 1'b1;
    @(posedge clk); #1;
    step = 1'b0;
  endtask

  task automatic wait_valid(inout int cyc);
    while (!out_valid && cyc < 200) begin
      @(posedge clk); #1;
      cyc++;
    end
    if (!out_valid) chk("valid_timeout", out_valid, 1);
  endtask

  task automatic wait_word(input int a);
    int n = 0;
    while (!(out_valid && out_addr == ADDR_W'(a)) && n < 300) begin
      @(posedge clk); #1;
      n++;
    end
    if (n >= 300) chk("word_timeout", {out_valid, out_addr}, {1'b1, ADDR_W'(a)});
  endtask

  task automatic wait_done();
    int n = 0;
    while (!done && n < 500) begin
      @(posedge clk); #1;
      n++;
    end
    chk("done_reached", done, 1);
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_rom_addr"},  rom_addr,  0);
    chk({tag, "_out_data"},  out_data,  0);
    chk({tag, "_out_addr"},  out_addr,  0);
    chk({tag, "_out_valid"}, out_valid, 0);
    chk({tag, "_sum"},       sum,       0);
    chk({tag, "_busy"},      busy,      0);
    chk({tag, "_done"},      done,      0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int cyc;
    bit bad;
    logic [ADDR_W+DATA_W+SUM_W:0] snap;

    rst_n = 1'b0; start = 1'b0; mode_auto = 1'b1; step = 1'b0; out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check_all_zero("reset");
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Auto scan, ready held high: latency, spacing, sum and completion.
    push_scan();
    pulse_start();
    chk("start_busy", busy, 1);
    cyc = 1;
    wait_valid(cyc);
    chk("first_latency", cyc, 2);
    cyc = 1;
    @(posedge clk); #1;
    chk("valid_drops", out_valid, 0);
    wait_valid(cyc);
    chk("valid_spacing", cyc, 2 + TICK_DIV);
    wait_done();
    chk("auto_busy", busy, 0);
    chk("auto_sum", sum, 23);
    chk("auto_drained", exp_q.size(), 0);

    // Backpressure at address 3.
    push_scan();
    pulse_start();
    chk("restart_done_clr", done, 0);
    wait_word(2);
    @(posedge clk); #1;
    out_ready = 1'b0;
    cyc = 0;
    wait_valid(cyc);
    chk("bp_addr", out_addr, 3);
    chk("bp_data", out_data, 5);
    chk("bp_sum", sum, 13);
    snap = {out_valid, out_addr, out_data, sum};
    bad = 1'b0;
    repeat (10) begin
      @(posedge clk); #1;
      if ({out_valid, out_addr, out_data, sum} !== snap) bad = 1'b1;
    end
    chk("bp_stable", bad, 0);
    out_ready = 1'b1;
    wait_done();
    chk("bp_sum_final", sum, 23);

    // Manual stepping.
    push_scan();
    mode_auto = 1'b0;
    pulse_start();
    mode_auto = 1'b1;
    cyc = 1;
    wait_valid(cyc);
    @(posedge clk); #1;
    bad = 1'b0;
    repeat (20) begin
      @(posedge clk); #1;
      if (out_valid) bad = 1'b1;
    end
    chk("man_stall", bad, 0);
    chk("man_stall_addr", rom_addr, 1);
    out_ready = 1'b0;
    pulse_step();
    cyc = 1;
    wait_valid(cyc);
    chk("man_step_latency", cyc, 2);
    chk("man_step_addr", out_addr, 1);
    pulse_step();
    pulse_step();
    out_ready = 1'b1;
    @(posedge clk); #1;
    bad = 1'b0;
    repeat (5) begin
      @(posedge clk); #1;
      if (out_valid) bad = 1'b1;
    end
    chk("man_step_not_queued", bad, 0);
    for (int unsigned a = 2; a < 8; a++) begin
      pulse_step();
      cyc = 1;
      wait_valid(cyc);
      chk("man_addr", out_addr, a);
      @(posedge clk); #1;
    end
    chk("man_done", done, 1);
    chk("man_sum", sum, 23);

    // start while busy, and start coinciding with the final accept.
    push_scan();
    pulse_start();
    wait_word(4);
    pulse_start();
    chk("busy_start_ignored", busy, 1);
    wait_word(7);
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    chk("last_accept_done", done, 1);
    repeat (3) @(posedge clk);
    #1;
    chk("last_start_dropped_busy", busy, 0);
    chk("last_start_dropped_valid", out_valid, 0);
    chk("last_start_sum", sum, 23);

    // New scan after done, then asynchronous reset at address 5.
    push_scan();
    pulse_start();
    chk("new_scan_sum", sum, 0);
    chk("new_scan_done", done, 0);
    chk("new_scan_busy", busy, 1);
    wait_word(5);
    #2;
    rst_n = 1'b0;
    #1;
    check_all_zero("async_rst");
    exp_q.delete();
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("post_rst_done", done, 0);

    push_scan();
    pulse_start();
    wait_done();
    chk("clean_sum", sum, 23);
    chk("clean_drained", exp_q.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
